// File: rtl/bus_xfer_controller_pkg.sv
// Shared encodings for the bus transfer controller: FSM states, grant codes and slave indices.
package bus_xfer_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic [1:0] GRANT_M1 = 2'b10;
    localparam logic [1:0] GRANT_M2 = 2'b01;

    localparam logic [1:0] SLV0 = 2'd0;
    localparam logic [1:0] SLV1 = 2'd1;
    localparam logic [1:0] SLV2 = 2'd2;
    localparam logic [1:0] SLV3 = 2'd3;

    function automatic logic [3:0] slave_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        oh = '0;
        unique case (idx)
            SLV0: oh = 4'b0001;
            SLV1: oh = 4'b0010;
            SLV2: oh = 4'b0100;
            SLV3: oh = 4'b1000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bus_xfer_controller_timer.sv
// Watchdog for the ACCESS phase: counts cycles without ready, flags expiry on the
// TIMEOUT-th such cycle, saturates instead of wrapping.
module xfer_timeout_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is combinational so the edge that would reach TIMEOUT is the one that ends ACCESS.
    assign expire = enable && (count >= LAST);

endmodule

// File: rtl/bus_xfer_controller.sv
// Sequences one granted master request onto the shared slave bus, waits for the
// selected slave's ready under a watchdog, and returns a one-cycle done to the owner.
module bus_xfer_controller
    import bus_xfer_controller_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            grant,
    input  logic [1:0]            m_valid,
    input  logic [1:0]            m_we,
    input  logic [2*ADDR_W-1:0]   m_addr,
    input  logic [2*DATA_W-1:0]   m_wdata,
    output logic [1:0]            m_done,
    output logic                  m_err,
    output logic [DATA_W-1:0]     m_rdata,
    output logic                  busy,
    output logic [3:0]            s_sel,
    output logic                  s_we,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    input  logic [4*DATA_W-1:0]   s_rdata,
    input  logic [3:0]            s_ready
);

    state_t state, state_nxt;

    logic              owner, owner_nxt;   // 1 = master1, 0 = master2
    logic              busy_nxt;
    logic [3:0]        s_sel_nxt;
    logic              s_we_nxt;
    logic [ADDR_W-1:0] s_addr_nxt;
    logic [DATA_W-1:0] s_wdata_nxt;
    logic [1:0]        m_done_nxt;
    logic              m_err_nxt;
    logic [DATA_W-1:0] m_rdata_nxt;

    logic              accept;
    logic              req_owner;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic [1:0]        sel_idx;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              tmr_clear;
    logic              tmr_enable;
    logic              tmr_expire;

    assign accept    = ((grant == GRANT_M1) && m_valid[1]) || ((grant == GRANT_M2) && m_valid[0]);
    assign req_owner = grant[1];
    assign req_we    = req_owner ? m_we[1] : m_we[0];
    assign req_addr  = req_owner ? m_addr[2*ADDR_W-1:ADDR_W]  : m_addr[ADDR_W-1:0];
    assign req_wdata = req_owner ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];

    // The held slave address doubles as the latched request address during ACCESS.
    assign sel_idx   = s_addr[ADDR_W-1 -: 2];
    assign sel_ready = s_ready[sel_idx];
    assign sel_rdata = s_rdata[int'(sel_idx)*DATA_W +: DATA_W];

    assign tmr_clear  = (state != ST_ACCESS);
    assign tmr_enable = (state == ST_ACCESS) && !sel_ready;

    xfer_timeout_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expire (tmr_expire)
    );

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        busy_nxt    = busy;
        s_sel_nxt   = s_sel;
        s_we_nxt    = s_we;
        s_addr_nxt  = s_addr;
        s_wdata_nxt = s_wdata;
        m_done_nxt  = '0;
        m_err_nxt   = m_err;
        m_rdata_nxt = m_rdata;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt   = ST_ACCESS;
                    owner_nxt   = req_owner;
                    busy_nxt    = 1'b1;
                    s_sel_nxt   = slave_onehot(req_addr[ADDR_W-1 -: 2]);
                    s_we_nxt    = req_we;
                    s_addr_nxt  = req_addr;
                    s_wdata_nxt = req_wdata;
                end
            end
            ST_ACCESS: begin
                // Ready is tested first so a ready on the expiry edge still returns data.
                if (sel_ready || tmr_expire) begin
                    state_nxt   = ST_RESP;
                    s_sel_nxt   = '0;
                    s_we_nxt    = 1'b0;
                    s_addr_nxt  = '0;
                    s_wdata_nxt = '0;
                    m_done_nxt  = owner ? 2'b10 : 2'b01;
                    m_err_nxt   = !sel_ready;
                    m_rdata_nxt = (sel_ready && !s_we) ? sel_rdata : '0;
                end
            end
            ST_RESP: begin
                state_nxt   = ST_IDLE;
                busy_nxt    = 1'b0;
                m_err_nxt   = 1'b0;
                m_rdata_nxt = '0;
            end
            default: begin
                state_nxt   = ST_IDLE;
                busy_nxt    = 1'b0;
                s_sel_nxt   = '0;
                s_we_nxt    = 1'b0;
                s_addr_nxt  = '0;
                s_wdata_nxt = '0;
                m_err_nxt   = 1'b0;
                m_rdata_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= 1'b0;
            busy    <= 1'b0;
            s_sel   <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_done  <= '0;
            m_err   <= 1'b0;
            m_rdata <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            busy    <= busy_nxt;
            s_sel   <= s_sel_nxt;
            s_we    <= s_we_nxt;
            s_addr  <= s_addr_nxt;
            s_wdata <= s_wdata_nxt;
            m_done  <= m_done_nxt;
            m_err   <= m_err_nxt;
            m_rdata <= m_rdata_nxt;
        end
    end

endmodule

// File: doc/bus_xfer_controller.md
Name: bus_xfer_controller

Overview:
- Transaction sequencer between the 2-master bus arbiter and the 4 slaves on the unidirectional bus.
- Takes the currently granted master's request and latches it.
- Decodes the address to one slave select and drives the shared slave-side bus.
- Waits for slave ready under a watchdog timeout, then returns a one-cycle done with read data or error to the owning master; `busy` lets the arbiter hold its grant.

Parameters:
- ADDR_W, 8, address width; bits [ADDR_W-1:ADDR_W-2] select the slave (00→slave0 … 11→slave3).
- DATA_W, 8, data width.
- TIMEOUT, 15, max ACCESS cycles without s_ready before an error response (≥1).
- CNT_W, 4, timer width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- grant  in  2  one-hot grant from arbiter; bit1 = master1 (high priority), bit0 = master2.
- m_valid  in  2  per-master request valid, held until m_done.
- m_we  in  2  per-master write enable (1 = write, 0 = read).
- m_addr  in  2*ADDR_W  flattened; [ADDR_W-1:0] = master2, upper half = master1.
- m_wdata  in  2*DATA_W  flattened, same packing.
- m_done  out  2  one-cycle completion pulse to the owning master.
- m_err  out  1  timeout error, qualified by m_done.
- m_rdata  out  DATA_W  read data, qualified by m_done.
- busy  out  1  high from request acceptance through the RESP cycle.
- s_sel  out  4  one-hot slave select.
- s_we  out  1  slave write enable.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_rdata  in  4*DATA_W  flattened; slice i = slave i.
- s_ready  in  4  per-slave ready / acknowledge.

Behaviour:
- Reset (async, any time including mid-transaction): state IDLE, timer 0, all outputs 0; latched request discarded, no m_done issued.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If grant is 10 or 01 and m_valid of that master is 1: latch owner index, addr, we, wdata; busy←1; go to ACCESS.
  - grant 00 or 11 (illegal): stay IDLE, no action.
  - Granted master with m_valid=0: stay IDLE.
- ACCESS:
  - s_sel = one-hot of latched addr top 2 bits; s_we/s_addr/s_wdata = latched values, stable the whole state.
  - Each edge: if s_ready[sel]=1, capture s_rdata slice sel into m_rdata (0 if write), m_err←0, go to RESP.
  - Otherwise timer++. When the timer reaches TIMEOUT, m_err←1, m_rdata←0, go to RESP.
  - If ready and timeout occur on the same edge, ready wins.
  - s_ready of non-selected slaves is ignored.
- RESP (exactly 1 cycle):
  - m_done[owner]=1, m_err/m_rdata valid; s_sel=0, s_we=0; timer cleared.
  - Next state IDLE; busy drops at the end of this cycle.
- Latency: request sampled at edge N; s_sel high in cycle N+1; with s_ready high in cycle N+1, m_done in cycle N+2. Minimum is 3 cycles per transaction including the IDLE accept.
- Grant or m_valid changes during ACCESS/RESP are ignored; the transaction completes on the latched owner.
- Back-to-back: a new request is accepted no earlier than the IDLE cycle after RESP.
- Timer saturates and never wraps.

Decomposition:
- Shared package/header holds:
  - State encodings IDLE=2'b00, ACCESS=2'b01, RESP=2'b10.
  - GRANT_M1=2'b10, GRANT_M2=2'b01.
  - Slave index constants 0–3.
- One sub-module: xfer_timeout_timer (clear/enable/expire at TIMEOUT, saturating).
- Address decode and rdata mux stay inline.

Test Plan:
- Read from master1: grant=10, m_valid=10, addr=8'hC5, slave3 ready in the first ACCESS cycle with rdata=8'h3C → s_sel=4'b1000 for 1 cycle, m_done=10 one cycle later, m_rdata=8'h3C, m_err=0.
- Write from master2: grant=01, addr=8'h12, wdata=8'hA7, slave0 ready after 4 cycles → s_sel=4'b0001 held 5 cycles, s_we=1, s_wdata=8'hA7, m_done=01, m_err=0.
- Timeout: addr=8'h40, slave1 never ready, TIMEOUT=15 → s_sel=4'b0010 for 15 cycles, then m_done pulses with m_err=1, m_rdata=0.
- Ready on the same edge as timeout → m_err=0 and the slave rdata is returned.
- Grant switches 10→01 during ACCESS → master1's transaction completes, m_done=10. Master2 is then served, with its s_sel asserted no earlier than 2 cycles after master1's m_done (IDLE accept, then ACCESS).
- Reset asserted mid-ACCESS → s_sel, busy, m_done go to 0 immediately (asynchronously); after release, FSM is IDLE; grant=11 is ignored with busy staying 0.
